byte_sequence_tx: RTL and testbench

//  Consumer end of the push-button "send next" path. Each one-cycle send_next pulse

---
 rtl/tx_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 47 ++++
 rtl/byte_sequence_tx.sv | 173 +++++++++++++++++
 tb/tb_byte_sequence_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants, state encoding and sizing helpers for byte_sequence_tx.
package tx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        UART_IDLE = 1'b1;

  // Legacy-compatible state encoding
  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  // Clocks per bit; never below one so the timer always has a valid terminal count
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned div;
    div = clk_freq / baud;
    return (div < 1) ? 1 : div;
  endfunction

  // Counter width for a modulus of n, at least one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// restart holds the count at zero so the first bit after restart gets full width.
module uart_bit_timer
  import tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((BAUD_DIV > 1) ? BAUD_DIV - 2 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero on restart, reload after the last cycle of a bit
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // bit_tick: last cycle of the bit; pre_tick: the cycle before it (only exists for BAUD_DIV>1)
  assign bit_tick = !restart && (cnt_q == CNT_LAST);
  assign pre_tick = !restart && (BAUD_DIV > 1) && (cnt_q == CNT_PRE);

endmodule

// File: rtl/byte_sequence_tx.sv
// byte_sequence_tx: each send_next pulse sends the next table byte as one UART frame
// (start, 8 data bits LSB first, optional even parity, stop), idle-high line.
// Build option: define TX_PARITY_EN to insert an even-parity bit after the data bits.
module byte_sequence_tx
  import tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned NUM_BYTES = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              send_next,
  input  logic [7:0]                        tx_data,
  output logic [cnt_width(NUM_BYTES)-1:0]   byte_idx,
  output logic                              TX,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned IDX_W    = cnt_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state_q,   state_d;
  logic [DATA_BITS-1:0] sh_q,      sh_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
`ifdef TX_PARITY_EN
  logic                 parity_q,  parity_d;
`endif

  logic restart;
  logic bit_tick;
  logic pre_tick;

  // Timer is held while idle so the start bit begins a fresh bit period
  assign restart = (state_q == ST_IDLE);

  uart_bit_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  // Next-state and registered-output logic; TX is computed one cycle ahead of the line
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE;
        if (send_next) begin
          sh_d      = tx_data;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = ST_START;
`ifdef TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = sh_q[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = UART_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sh_d      = {1'b0, sh_q[DATA_BITS-1:1]};
            tx_d      = sh_q[1];
          end
        end
      end

`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          tx_d    = UART_IDLE;
        end
      end
`endif

      ST_STOP: begin
        if (bit_tick) begin
          state_d = ST_IDLE;
          tx_d    = UART_IDLE;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = UART_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // done must be high during the last stop cycle, so it is raised one cycle early;
    // with a one-clock bit the stop bit is its own last cycle, so raise it on entry
    done_d = ((state_q == ST_STOP) && pre_tick) ||
             ((BAUD_DIV == 1) && (state_q != ST_STOP) && (state_d == ST_STOP));
  end

  // State and output registers; reset aborts any frame and parks the line idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= 3'd0;
      idx_q     <= '0;
      tx_q      <= UART_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef TX_PARITY_EN
  // Parity of the accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign byte_idx = idx_q;
  assign TX       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_byte_sequence_tx.sv
// Directed-plus-random bench for byte_sequence_tx with BAUD_DIV=4, NUM_BYTES=3.
// Expected line levels come from a per-bit frame model built from the byte value.
module tb_byte_sequence_tx;

  localparam int unsigned NB  = 3;
  localparam int unsigned DIV = 4;
`ifdef TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_next = 1'b0;
  logic [7:0] tx_data;
  logic [1:0] byte_idx;
  logic       TX;
  logic       busy;
  logic       done;

  logic [7:0] msg_tab [4];
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  int errors = 0;
  int checks = 0;
  int exp_idx = 0;

  byte_sequence_tx #(
    .CLK_FREQ  (4),
    .BAUD      (1),
    .NUM_BYTES (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_next (send_next),
    .tx_data   (tx_data),
    .byte_idx  (byte_idx),
    .TX        (TX),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // External message table, read combinationally at byte_idx
  always_comb tx_data = ovr_en ? ovr_val : msg_tab[byte_idx];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line level during bit slot k of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if ((NBITS == 11) && (k == 9)) return ^b;
    return 1'b1;
  endfunction

  // Entered just after a posedge; pulses send_next and checks the whole frame cycle by cycle
  task automatic run_frame(input logic [7:0] b, input bit drop, input bit flip_data);
    send_next = 1'b1;
    @(posedge clk); #1;
    send_next = 1'b0;
    for (int k = 1; k <= int'(FRAME); k++) begin
      if (drop && (k == 10 || k == int'(FRAME))) send_next = 1'b1;
      if (flip_data && k == 2) ovr_val = ~ovr_val;
      @(negedge clk);
      chk("tx_bit", 32'(TX), 32'(frame_bit(b, (k - 1) / DIV)));
      chk("busy_frame", 32'(busy), 32'd1);
      chk("done_frame", 32'(done), 32'(k == int'(FRAME)));
      chk("idx_frame", 32'(byte_idx), 32'(exp_idx));
      @(posedge clk); #1;
      send_next = 1'b0;
    end
    exp_idx = (exp_idx + 1) % NB;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("tx_idle", 32'(TX), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("done_idle", 32'(done), 32'd0);
      chk("idx_after", 32'(byte_idx), 32'(exp_idx));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 4; i++) msg_tab[i] = 8'($urandom);
    msg_tab[0] = 8'hA5;

    // Reset state, with send_next asserted during reset
    send_next = 1'b1;
    #12;
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    @(posedge clk); #1;
    send_next = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_tx", 32'(TX), 32'd1);
      @(posedge clk); #1;
    end

    // Single frame of 8'hA5
    run_frame(msg_tab[0], 1'b0, 1'b0);

    // Wrap through the rest of the table
    run_frame(msg_tab[1], 1'b0, 1'b0);
    run_frame(msg_tab[2], 1'b0, 1'b0);
    chk("wrap_idx", 32'(byte_idx), 32'd0);

    // Pulses mid-frame and in the done cycle are dropped
    run_frame(msg_tab[0], 1'b1, 1'b0);

    // Reset mid-frame
    send_next = 1'b1;
    @(posedge clk); #1;
    send_next = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_idx = 0;
    chk("mid_rst_tx", 32'(TX), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_idx", 32'(byte_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (int'(FRAME)) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(done), 32'd0);
      chk("mid_rst_idle_tx", 32'(TX), 32'd1);
      @(posedge clk); #1;
    end
    run_frame(msg_tab[0], 1'b0, 1'b0);

    // Parity-sensitive bytes
    msg_tab[1] = 8'h07;
    msg_tab[2] = 8'h03;
    run_frame(msg_tab[1], 1'b0, 1'b0);
    run_frame(msg_tab[2], 1'b0, 1'b0);

    // Data changes after the accept cycle do not reach the line
    ovr_val = 8'($urandom);
    ovr_en  = 1'b1;
    b = ovr_val;
    run_frame(b, 1'b0, 1'b1);
    ovr_en = 1'b0;

    // Random table contents and idle gaps
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(NB); i++) msg_tab[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      b = msg_tab[exp_idx];
      run_frame(b, r[0], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
